// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and helpers for the iterative divider
package div_unit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = $clog2(DEF_WIDTH);
   localparam int MAX_W     = 64;

   // value holds a width-bit operand in its low bits; result is its
   // width+1-bit magnitude, zero-extended to MAX_W+1 bits
   function automatic logic [MAX_W:0] abs_ext(input logic [MAX_W:0] value,
                                              input logic            is_signed,
                                              input int              width);
      logic [MAX_W:0] hi_mask;
      logic [MAX_W:0] msb_sh;
      logic [MAX_W:0] res;
      hi_mask = {(MAX_W + 1){1'b1}} << width;
      msb_sh  = value >> (width - 1);
      if (is_signed && msb_sh[0]) begin
         res = -(value | hi_mask);
      end else begin
         res = value & ~hi_mask;
      end
      return res & ~(hi_mask << 1);
   endfunction

endpackage

// File: rtl/div_unit_step.sv
// rtl/div_unit_step.sv - one restoring division iteration (combinational)
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0] rem_i,
   input  logic           bit_i,
   input  logic [WIDTH:0] dsr_i,
   output logic [WIDTH:0] rem_o,
   output logic           q_o
);

   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      shifted = {rem_i, bit_i};
      diff    = shifted - {1'b0, dsr_i};
      q_o     = ~diff[WIDTH+1];
      rem_o   = diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
   end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider with early-out
// and divide-by-zero fast paths; results held until acknowledged
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int EARLY_OUT = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   input  logic             annul_i,
   input  logic             ack_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             dbz_o
);

   localparam int CNT_W = (WIDTH == DEF_WIDTH) ? DEF_CNT_W : $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sign_a_q, sign_a_d;
   logic             neg_q_q, neg_q_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH:0]   dsr_q, dsr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;

   logic [MAX_W:0]   a_wide, b_wide;
   logic [MAX_W:0]   a_abs, b_abs;
   logic [WIDTH:0]   step_rem;
   logic             step_q;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i (rem_q),
      .bit_i (dvd_q[WIDTH-1]),
      .dsr_i (dsr_q),
      .rem_o (step_rem),
      .q_o   (step_q)
   );

   always_comb begin
      a_wide              = '0;
      b_wide              = '0;
      a_wide[WIDTH-1:0]   = dividend_i;
      b_wide[WIDTH-1:0]   = divisor_i;
      a_abs               = abs_ext(a_wide, signed_i, WIDTH);
      b_abs               = abs_ext(b_wide, signed_i, WIDTH);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      neg_q_d  = neg_q_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      quot_d   = quot_q;
      rmd_d    = rmd_q;
      dbz_d    = dbz_q;

      // annul wins over everything and leaves the result registers untouched
      if (annul_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  if (divisor_i == '0) begin
                     quot_d  = '1;
                     rmd_d   = dividend_i;
                     dbz_d   = 1'b1;
                     state_d = DONE;
                  end else if ((EARLY_OUT != 0) && (a_abs < b_abs)) begin
                     quot_d  = '0;
                     rmd_d   = dividend_i;
                     dbz_d   = 1'b0;
                     state_d = DONE;
                  end else begin
                     sign_a_d = signed_i & dividend_i[WIDTH-1];
                     neg_q_d  = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                     rem_d    = '0;
                     dvd_d    = a_abs[WIDTH-1:0];
                     dsr_d    = b_abs[WIDTH:0];
                     cnt_d    = '0;
                     state_d  = CALC;
                  end
               end
            end
            CALC: begin
               // quotient bits shift in behind the dividend bits being consumed
               rem_d = step_rem;
               dvd_d = {dvd_q[WIDTH-2:0], step_q};
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_d = FIX;
               end
            end
            FIX: begin
               quot_d  = neg_q_q ? -dvd_q : dvd_q;
               rmd_d   = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
               dbz_d   = 1'b0;
               state_d = DONE;
            end
            DONE: begin
               if (ack_i) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         neg_q_q  <= 1'b0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         quot_q   <= '0;
         rmd_q    <= '0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         neg_q_q  <= neg_q_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         quot_q   <= quot_d;
         rmd_q    <= rmd_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign quotient_o  = quot_q;
   assign remainder_o = rmd_q;
   assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench: two dividers (EARLY_OUT 1 and 0)
// driven in lockstep against an arithmetic reference model
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start_i = 1'b0;
   logic        signed_i = 1'b0;
   logic        annul_i = 1'b0;
   logic        ack_i = 1'b0;
   logic [31:0] dividend_i = '0;
   logic [31:0] divisor_i = '0;

   logic [1:0]       busy_w, done_w, dbz_w;
   logic [1:0][31:0] q_w, r_w;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t cur[2];
   exp_t last[2];
   bit   cur_ok[2];
   bit   seen[2];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cyc = 0;

   div_unit #(.WIDTH(32), .EARLY_OUT(1)) dut0 (
      .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i), .ack_i(ack_i),
      .busy_o(busy_w[0]), .done_o(done_w[0]), .quotient_o(q_w[0]),
      .remainder_o(r_w[0]), .dbz_o(dbz_w[0])
   );

   div_unit #(.WIDTH(32), .EARLY_OUT(0)) dut1 (
      .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
      .dividend_i(dividend_i), .divisor_i(divisor_i), .annul_i(annul_i), .ack_i(ack_i),
      .busy_o(busy_w[1]), .done_o(done_w[1]), .quotient_o(q_w[1]),
      .remainder_o(r_w[1]), .dbz_o(dbz_w[1])
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d: got %h required %h", nm, d, act, exp);
      end
   endtask

   function automatic exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  input bit early);
      exp_t   e;
      longint sa, sb, ma, mb;
      sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      e.dbz = 1'b0;
      e.lat = 34;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1; e.lat = 1;
      end else if (early && (ma < mb)) begin
         e.q = 32'd0; e.r = a; e.lat = 1;
      end else begin
         e.q = 32'(sa / sb);
         e.r = 32'(sa % sb);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!resetn || !done_w[d]) begin
            seen[d] = 1'b0;
         end else if (!seen[d]) begin
            seen[d] = 1'b1;
            cur_ok[d] = 1'b0;
            if (d == 0 && sb0.size() > 0) begin
               cur[d] = sb0.pop_front(); cur_ok[d] = 1'b1;
            end else if (d == 1 && sb1.size() > 0) begin
               cur[d] = sb1.pop_front(); cur_ok[d] = 1'b1;
            end
            if (!cur_ok[d]) begin
               chk("unexpected_done", d, {31'b0, done_w[d]}, 32'd0);
            end else begin
               chk("quotient", d, q_w[d], cur[d].q);
               chk("remainder", d, r_w[d], cur[d].r);
               chk("dbz", d, {31'b0, dbz_w[d]}, {31'b0, cur[d].dbz});
               chk("latency", d, 32'(cyc - start_cyc + 1), 32'(cur[d].lat));
            end
         end else if (cur_ok[d]) begin
            chk("hold_quotient", d, q_w[d], cur[d].q);
            chk("hold_remainder", d, r_w[d], cur[d].r);
            chk("hold_dbz", d, {31'b0, dbz_w[d]}, {31'b0, cur[d].dbz});
         end
      end
   end

   task automatic check_zero(input string nm);
      for (int d = 0; d < 2; d++) begin
         chk({nm, "_busy"}, d, {31'b0, busy_w[d]}, 32'd0);
         chk({nm, "_done"}, d, {31'b0, done_w[d]}, 32'd0);
         chk({nm, "_quotient"}, d, q_w[d], 32'd0);
         chk({nm, "_remainder"}, d, r_w[d], 32'd0);
         chk({nm, "_dbz"}, d, {31'b0, dbz_w[d]}, 32'd0);
      end
   endtask

   task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
      exp_t e0, e1;
      bit   ok;
      @(negedge clk);
      start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
      e0 = model(sgn, a, b, 1'b1);
      e1 = model(sgn, a, b, 1'b0);
      sb0.push_back(e0); sb1.push_back(e1);
      last[0] = e0; last[1] = e1;
      @(posedge clk);
      #1 start_cyc = cyc;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (&done_w) begin
            ok = 1'b1;
         end else begin
            // stray starts while busy must not disturb the operation
            start_i = ($urandom_range(0, 3) == 0);
            signed_i = 1'($urandom);
            dividend_i = $urandom;
            divisor_i = $urandom;
         end
      end
      start_i = 1'b0;
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL timeout: done_o=%b required 11", done_w);
         annul_i = 1'b1;
         sb0.delete(); sb1.delete();
         @(negedge clk);
         annul_i = 1'b0;
      end else begin
         repeat (hold) @(negedge clk);
         ack_i = 1'b1;
         start_i = 1'b1; signed_i = 1'b0; dividend_i = $urandom; divisor_i = 32'd0;
         @(negedge clk);
         ack_i = 1'b0; start_i = 1'b0;
         for (int d = 0; d < 2; d++) begin
            chk("busy_after_ack", d, {31'b0, busy_w[d]}, 32'd0);
            chk("done_after_ack", d, {31'b0, done_w[d]}, 32'd0);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, b;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      resetn = 1'b1;

      run_op(1'b0, 32'd100, 32'd7, 0);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(1'b0, 32'd5, 32'd0, 0);
      run_op(1'b0, 32'd3, 32'd10, 5);

      // annul during CALC, then annul beating a start in IDLE
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b1; dividend_i = 32'd100000; divisor_i = 32'd3;
      @(posedge clk);
      #1 start_cyc = cyc;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      annul_i = 1'b1; start_i = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("annul_busy", d, {31'b0, busy_w[d]}, 32'd0);
         chk("annul_done", d, {31'b0, done_w[d]}, 32'd0);
         chk("annul_quotient", d, q_w[d], last[d].q);
         chk("annul_remainder", d, r_w[d], last[d].r);
         chk("annul_dbz", d, {31'b0, dbz_w[d]}, {31'b0, last[d].dbz});
      end
      @(negedge clk);
      annul_i = 1'b0; start_i = 1'b0;
      for (int d = 0; d < 2; d++) chk("annul_beats_start", d, {31'b0, busy_w[d]}, 32'd0);
      repeat (40) @(negedge clk);
      run_op(1'b0, 32'd20, 32'd4, 2);

      for (int n = 0; n < 40; n++) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: b = 32'($urandom_range(1, 15));
            2: b = 32'hFFFF_FFFF;
            3: begin b = 32'hFFFF_FFFF; a = 32'h8000_0000; end
            4: begin b = $urandom; a = 32'($urandom_range(0, 1000)); end
            default: b = $urandom;
         endcase
         run_op(1'($urandom), a, b, $urandom_range(0, 5));
      end

      // asynchronous reset mid-CALC
      @(negedge clk);
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd7;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      #2 resetn = 1'b0;
      #1 check_zero("midreset");
      @(negedge clk);
      resetn = 1'b1;
      run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
